// File: rtl/pc_seq_if.sv
// ---------------------------------------------------------------------------
// pc_seq_if -- bundle between the fetch-address sequencer and its neighbours
// (hazard unit, CP0, IF stage).
//
// Signals (named from the sequencer's point of view):
//   stall_i      hazard-unit freeze of IF/ID
//   irq_i        CP0 interrupt/exception request (highest priority)
//   eret_i       eret resolved in D
//   epc_i[31:0]  return address from CP0
//   br_i         taken branch/jump resolved in D
//   br_target_i  branch/jump target
//   pc_o[31:0]   current fetch address
//   pc_valid_o   pc_o is a real fetch (0 = bubble)
//   flush_o      one-cycle IF/ID flush on interrupt entry
//   exc_adel_o   fetch address error
//   state_o[2:0] sequencer FSM state (debug)
//   redir_cnt_o  redirect counter, only when PC_SEQ_REDIR_CNT_EN is defined
//
// Modports: master = environment driving requests, slave = pc_seq.
// Optional feature macro: PC_SEQ_REDIR_CNT_EN
// ---------------------------------------------------------------------------
interface pc_seq_if;
  logic        stall_i;
  logic        irq_i;
  logic        eret_i;
  logic [31:0] epc_i;
  logic        br_i;
  logic [31:0] br_target_i;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        flush_o;
  logic        exc_adel_o;
  logic [2:0]  state_o;
`ifdef PC_SEQ_REDIR_CNT_EN
  logic [15:0] redir_cnt_o;
`endif

  modport master (
    output stall_i, irq_i, eret_i, epc_i, br_i, br_target_i,
    input  pc_o, pc_valid_o, flush_o, exc_adel_o, state_o
`ifdef PC_SEQ_REDIR_CNT_EN
    , input redir_cnt_o
`endif
  );

  modport slave (
    input  stall_i, irq_i, eret_i, epc_i, br_i, br_target_i,
    output pc_o, pc_valid_o, flush_o, exc_adel_o, state_o
`ifdef PC_SEQ_REDIR_CNT_EN
    , output redir_cnt_o
`endif
  );
endinterface

// File: rtl/pc_seq.sv
// ---------------------------------------------------------------------------
// pc_seq -- fetch-address sequencer for the 5-stage MIPS pipeline.
// Owns the architectural PC and each cycle advances it, holds it, or
// redirects it (interrupt entry, eret, taken branch/jump). A redirect that
// arrives while IF/ID is stalled is captured and replayed on stall release.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    pc_seq_if.slave (requests in, pc/status out)
//
// Optional feature macro: PC_SEQ_REDIR_CNT_EN
//   defined   -> bus.redir_cnt_o counts non-sequential PC loads (saturating)
//   undefined -> counter absent, behaviour otherwise identical
// ---------------------------------------------------------------------------
module pc_seq #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PC_MIN     = 32'h0000_3000,
  parameter logic [31:0] PC_MAX     = 32'h0000_6ffc
) (
  input  logic    clk,
  input  logic    reset,
  pc_seq_if.slave bus
);

  typedef enum logic [2:0] {
    ST_BOOT = 3'd0,
    ST_RUN  = 3'd1,
    ST_HOLD = 3'd2,
    ST_PEND = 3'd3,
    ST_EXC  = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pend_addr;
  logic        r_valid;
  logic        r_flush;

  logic [31:0] w_norm_pc;
  logic [31:0] w_cap_addr;

  // Misaligned or out-of-window fetch address.
  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < PC_MIN) || (a > PC_MAX);
  endfunction

  // Unstalled next PC and stall-capture address; eret outranks branch in both.
  always_comb begin
    w_norm_pc  = r_pc + 32'd4;
    w_cap_addr = bus.br_target_i;
    if (bus.eret_i) begin
      w_norm_pc  = bus.epc_i;
      w_cap_addr = bus.epc_i;
    end else if (bus.br_i) begin
      w_norm_pc  = bus.br_target_i;
      w_cap_addr = bus.br_target_i;
    end else begin
      w_norm_pc  = r_pc + 32'd4;
      w_cap_addr = bus.br_target_i;
    end
  end

  // Sequencer FSM: PC, pending redirect, valid and flush, all registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_BOOT;
      r_pc        <= RESET_PC;
      r_pend_addr <= 32'd0;
      r_valid     <= 1'b0;
      r_flush     <= 1'b0;
    end else begin
      r_flush <= 1'b0;
      case (r_state)
        ST_BOOT: begin
          // pc already holds RESET_PC; the first real fetch is next cycle
          r_state <= ST_RUN;
          r_valid <= 1'b1;
        end
        ST_RUN, ST_HOLD, ST_PEND: begin
          if (bus.irq_i) begin
            // interrupt entry overrides stall and drops any pending redirect
            r_pc    <= HANDLER_PC;
            r_state <= ST_EXC;
            r_valid <= 1'b0;
            r_flush <= 1'b1;
          end else if (bus.stall_i) begin
            r_valid <= 1'b1;
            if (r_state == ST_PEND) begin
              // first captured redirect wins; later requests are ignored
              r_state <= ST_PEND;
            end else if (bus.eret_i || bus.br_i) begin
              r_pend_addr <= w_cap_addr;
              r_state     <= ST_PEND;
            end else begin
              r_state <= ST_HOLD;
            end
          end else if (r_state == ST_PEND) begin
            r_pc    <= r_pend_addr;
            r_state <= ST_RUN;
            r_valid <= 1'b1;
          end else begin
            r_pc    <= w_norm_pc;
            r_state <= ST_RUN;
            r_valid <= 1'b1;
          end
        end
        ST_EXC: begin
          // bubble for the flushed slot; handler fetch starts next cycle
          r_state <= ST_RUN;
          r_valid <= 1'b1;
        end
        default: begin
          // unreachable encoding: recover through BOOT
          r_state <= ST_BOOT;
          r_pc    <= RESET_PC;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_o       = r_pc;
  assign bus.pc_valid_o = r_valid;
  assign bus.flush_o    = r_flush;
  assign bus.state_o    = r_state;
  assign bus.exc_adel_o = r_valid & addr_err(r_pc);

`ifdef PC_SEQ_REDIR_CNT_EN
  logic        w_redir_load;
  logic [15:0] r_redir_cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hffff) ? v : (v + 16'd1);
  endfunction

  // Flags edges that load a non-sequential pc (irq, eret, br, replay).
  always_comb begin
    w_redir_load = 1'b0;
    if ((r_state == ST_RUN) || (r_state == ST_HOLD) || (r_state == ST_PEND)) begin
      if (bus.irq_i) begin
        w_redir_load = 1'b1;
      end else if (bus.stall_i) begin
        w_redir_load = 1'b0;
      end else if (r_state == ST_PEND) begin
        w_redir_load = 1'b1;
      end else begin
        w_redir_load = bus.eret_i | bus.br_i;
      end
    end else begin
      w_redir_load = 1'b0;
    end
  end

  // Saturating redirect counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_redir_cnt <= 16'd0;
    end else if (w_redir_load) begin
      r_redir_cnt <= sat_inc(r_redir_cnt);
    end else begin
      r_redir_cnt <= r_redir_cnt;
    end
  end

  assign bus.redir_cnt_o = r_redir_cnt;
`endif

endmodule
